// File: rtl/chinx_pkg.sv
// Shared types for the chinx fetch-stage PC sequencer: FSM states and the
// pending-redirect entry.
package chinx_pkg;

  // Stored redirect targets are zero-extended to this width; ADDR_WIDTH must not exceed it.
  localparam int unsigned REDIR_TGT_W = 64;

  typedef enum logic [1:0] {
    PC_BOOT,
    PC_RUN,
    PC_HOLD
  } pc_state_t;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_BR,
    REDIR_EXC
  } redir_kind_t;

  typedef struct packed {
    redir_kind_t             kind;
    logic [REDIR_TGT_W-1:0]  target;
  } redir_t;

  localparam redir_t REDIR_IDLE = '{kind: REDIR_NONE, target: '0};

endpackage

// File: rtl/chinx_pc_redir_arb.sv
// Combinational next-PC priority select and stalled-redirect merge for chinx_pc_gen.
module chinx_pc_redir_arb
  import chinx_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_BYTES = 4
) (
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  br_valid_i,
  input  logic [ADDR_WIDTH-1:0] br_target_i,
  input  logic                  exc_valid_i,
  input  logic [ADDR_WIDTH-1:0] exc_target_i,
  input  redir_t                pend_i,
  output logic [ADDR_WIDTH-1:0] next_pc_o,
  output logic                  redirect_o,
  output redir_t                pend_o
);

  localparam logic [ADDR_WIDTH-1:0] INC        = ADDR_WIDTH'(INST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(INC - ADDR_WIDTH'(1));

  logic [ADDR_WIDTH-1:0] br_tgt;
  logic [ADDR_WIDTH-1:0] exc_tgt;
  logic [ADDR_WIDTH-1:0] pend_tgt;

  always_comb begin
    br_tgt   = br_target_i & ALIGN_MASK;
    exc_tgt  = exc_target_i & ALIGN_MASK;
    pend_tgt = pend_i.target[ADDR_WIDTH-1:0] & ALIGN_MASK;
  end

  always_comb begin
    next_pc_o  = pc_i + INC;
    redirect_o = 1'b0;
    if (exc_valid_i) begin
      next_pc_o  = exc_tgt;
      redirect_o = 1'b1;
    end else if (pend_i.kind == REDIR_EXC) begin
      next_pc_o  = pend_tgt;
      redirect_o = 1'b1;
    end else if (br_valid_i) begin
      next_pc_o  = br_tgt;
      redirect_o = 1'b1;
    end else if (pend_i.kind == REDIR_BR) begin
      next_pc_o  = pend_tgt;
      redirect_o = 1'b1;
    end
  end

  // A branch arriving behind a pending exception is wrong-path and is dropped.
  always_comb begin
    pend_o = pend_i;
    if (exc_valid_i) begin
      pend_o.kind   = REDIR_EXC;
      pend_o.target = REDIR_TGT_W'(exc_tgt);
    end else if (br_valid_i && (pend_i.kind != REDIR_EXC)) begin
      pend_o.kind   = REDIR_BR;
      pend_o.target = REDIR_TGT_W'(br_tgt);
    end
  end

endmodule

// File: rtl/chinx_pc_gen.sv
// Fetch-stage PC sequencer: sequential stepping, prioritised branch/exception
// redirects, and buffering of redirects that arrive while the pipeline is stalled.
module chinx_pc_gen
  import chinx_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter int unsigned          INST_BYTES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  br_valid_i,
  input  logic [ADDR_WIDTH-1:0] br_target_i,
  input  logic                  exc_valid_i,
  input  logic [ADDR_WIDTH-1:0] exc_target_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  pc_valid_o,
  output logic                  flush_o
);

  pc_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic                  flush_q, flush_d;
  redir_t                pend_q, pend_d;

  logic [ADDR_WIDTH-1:0] arb_next_pc;
  logic                  arb_redirect;
  redir_t                arb_pend;

  chinx_pc_redir_arb #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_BYTES (INST_BYTES)
  ) u_arb (
    .pc_i         (pc_q),
    .br_valid_i   (br_valid_i),
    .br_target_i  (br_target_i),
    .exc_valid_i  (exc_valid_i),
    .exc_target_i (exc_target_i),
    .pend_i       (pend_q),
    .next_pc_o    (arb_next_pc),
    .redirect_o   (arb_redirect),
    .pend_o       (arb_pend)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    flush_d = 1'b0;
    pend_d  = pend_q;
    unique case (state_q)
      PC_BOOT: begin
        state_d = PC_RUN;
        valid_d = 1'b1;
      end
      PC_RUN: begin
        if (!stall_i) begin
          pc_d    = arb_next_pc;
          flush_d = arb_redirect;
        end else if (arb_pend.kind != REDIR_NONE) begin
          pend_d  = arb_pend;
          state_d = PC_HOLD;
        end
      end
      PC_HOLD: begin
        if (stall_i) begin
          pend_d = arb_pend;
        end else begin
          pc_d    = arb_next_pc;
          flush_d = arb_redirect;
          pend_d  = REDIR_IDLE;
          state_d = PC_RUN;
        end
      end
      default: state_d = PC_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PC_BOOT;
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      pend_q  <= REDIR_IDLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    pc_o       = pc_q;
    pc_valid_o = valid_q;
    flush_o    = flush_q;
  end

endmodule

// File: tb/tb_chinx_pc_gen.sv
// Directed scoreboard bench for chinx_pc_gen with default parameters.
module tb_chinx_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        br_valid_i;
  logic [31:0] br_target_i;
  logic        exc_valid_i;
  logic [31:0] exc_target_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        flush_o;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        flush;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  chinx_pc_gen #(
    .ADDR_WIDTH   (32),
    .RESET_VECTOR (32'hBFC0_0000),
    .INST_BYTES   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .br_valid_i   (br_valid_i),
    .br_target_i  (br_target_i),
    .exc_valid_i  (exc_valid_i),
    .exc_target_i (exc_target_i),
    .pc_o         (pc_o),
    .pc_valid_o   (pc_valid_o),
    .flush_o      (flush_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_outputs(input string tag, input logic [31:0] e_pc,
                               input logic e_valid, input logic e_flush);
    checks++;
    assert (pc_o === e_pc) else begin
      failures++;
      $error("FAIL %s.pc got=%h exp=%h", tag, pc_o, e_pc);
    end
    checks++;
    assert (pc_valid_o === e_valid) else begin
      failures++;
      $error("FAIL %s.valid got=%b exp=%b", tag, pc_valid_o, e_valid);
    end
    checks++;
    assert (flush_o === e_flush) else begin
      failures++;
      $error("FAIL %s.flush got=%b exp=%b", tag, flush_o, e_flush);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input string tag, input logic stall,
                      input logic br, input logic [31:0] bt,
                      input logic exc, input logic [31:0] et,
                      input logic [31:0] e_pc, input logic e_valid, input logic e_flush);
    exp_t e;
    stall_i      = stall;
    br_valid_i   = br;
    br_target_i  = bt;
    exc_valid_i  = exc;
    exc_target_i = et;
    e.tag   = tag;
    e.pc    = e_pc;
    e.valid = e_valid;
    e.flush = e_flush;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() == 1) else begin
      failures++;
      $error("FAIL %s.sb_depth got=%0d exp=1", tag, exp_q.size());
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_outputs(e.tag, e.pc, e.valid, e.flush);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    stall_i      = 1'b0;
    br_valid_i   = 1'b0;
    br_target_i  = '0;
    exc_valid_i  = 1'b0;
    exc_target_i = '0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 32'hBFC0_0000, 1'b0, 1'b0);
    rst = 1'b1;

    // Boot cycle ignores redirects.
    step("boot",     0, 1, 32'h1234_5678, 0, '0, 32'hBFC0_0000, 1, 0);
    step("seq4",     0, 0, '0, 0, '0, 32'hBFC0_0004, 1, 0);
    step("seq8",     0, 0, '0, 0, '0, 32'hBFC0_0008, 1, 0);

    step("br",       0, 1, 32'h8000_0102, 0, '0, 32'h8000_0100, 1, 1);
    step("br_next",  0, 0, '0, 0, '0, 32'h8000_0104, 1, 0);
    step("exc_pri",  0, 1, 32'h8000_0000, 1, 32'hBFC0_0380, 32'hBFC0_0380, 1, 1);
    step("exc_next", 0, 0, '0, 0, '0, 32'hBFC0_0384, 1, 0);

    step("stl1_br",  1, 1, 32'h8000_0040, 0, '0, 32'hBFC0_0384, 1, 0);
    step("stl2_exc", 1, 0, '0, 1, 32'hBFC0_0380, 32'hBFC0_0384, 1, 0);
    step("stl3_br",  1, 1, 32'h8000_0080, 0, '0, 32'hBFC0_0384, 1, 0);
    step("stl_rel",  0, 0, '0, 0, '0, 32'hBFC0_0380, 1, 1);
    step("stl_post", 0, 0, '0, 0, '0, 32'hBFC0_0384, 1, 0);

    step("bb_stl1",  1, 1, 32'h8000_0040, 0, '0, 32'hBFC0_0384, 1, 0);
    step("bb_stl2",  1, 1, 32'h8000_0080, 0, '0, 32'hBFC0_0384, 1, 0);
    step("bb_rel",   0, 0, '0, 0, '0, 32'h8000_0080, 1, 1);

    step("lb_stl",   1, 1, 32'h8000_0200, 0, '0, 32'h8000_0080, 1, 0);
    step("lb_rel",   0, 1, 32'h8000_0300, 0, '0, 32'h8000_0300, 1, 1);
    step("lb_post",  0, 0, '0, 0, '0, 32'h8000_0304, 1, 0);

    step("ns_stl",   1, 0, '0, 0, '0, 32'h8000_0304, 1, 0);
    step("ns_rel",   0, 0, '0, 0, '0, 32'h8000_0308, 1, 0);

    step("wrap_br",  0, 1, 32'hFFFF_FFFF, 0, '0, 32'hFFFF_FFFC, 1, 1);
    step("wrap0",    0, 0, '0, 0, '0, 32'h0000_0000, 1, 0);
    step("wrap4",    0, 0, '0, 0, '0, 32'h0000_0004, 1, 0);

    // Async reset while holding a pending branch.
    step("rh_stl",   1, 1, 32'h8000_0500, 0, '0, 32'h0000_0004, 1, 0);
    rst = 1'b0;
    #1;
    check_outputs("async_rst", 32'hBFC0_0000, 1'b0, 1'b0);
    stall_i    = 1'b0;
    br_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step("rh_boot",  0, 0, '0, 0, '0, 32'hBFC0_0000, 1, 0);
    step("rh_seq",   0, 0, '0, 0, '0, 32'hBFC0_0004, 1, 0);
    step("rh_seq2",  0, 0, '0, 0, '0, 32'hBFC0_0008, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chinx_pc_gen.md
# chinx_pc_gen

Parametrised program-counter generator for the chinx core. It replaces the plain PC register with a sequencer for the fetch stage: it produces the fetch address and a valid flag, steps sequentially by the instruction size, and applies branch and exception redirects with fixed priority. A redirect that arrives during a pipeline stall is buffered and applied when the stall releases.

## Interface
- `ADDR_WIDTH`, default 32: PC width in bits.
- `RESET_VECTOR`, default 32'hBFC0_0000: PC value loaded at reset.
- `INST_BYTES`, default 4: sequential increment. Power of two, ≥1.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `stall_i` in 1: fetch/pipeline cannot accept a new PC this cycle.
- `br_valid_i` in 1: branch/jump redirect request from EX.
- `br_target_i` in ADDR_WIDTH: branch target.
- `exc_valid_i` in 1: exception/return redirect request. Highest priority.
- `exc_target_i` in ADDR_WIDTH: exception or return target.
- `pc_o` out ADDR_WIDTH: current fetch PC. Registered.
- `pc_valid_o` out 1: `pc_o` is a valid fetch request. Registered.
- `flush_o` out 1: one-cycle pulse. `pc_o` has just taken a redirect value, so fetch discards in-flight instructions. Registered.

## Operation
- Reset values:
  - `pc_o`=RESET_VECTOR, `pc_valid_o`=0, `flush_o`=0.
  - Pending redirect = NONE. State = PC_BOOT.
- States:
  - **PC_BOOT**: first edge after reset release. Go to PC_RUN, set `pc_valid_o`=1, keep `pc_o`=RESET_VECTOR. All redirect inputs are ignored in this cycle.
  - **PC_RUN**, `stall_i`=0: `pc_o` gets the next value from the priority list below.
  - **PC_RUN**, `stall_i`=1: `pc_o` holds. Any redirect input is captured into the pending register and the state moves to PC_HOLD. With no redirect, stay in PC_RUN.
  - **PC_HOLD**, `stall_i`=1: `pc_o` holds and the pending register updates by the merge rule. Stay in PC_HOLD.
  - **PC_HOLD**, `stall_i`=0: `pc_o` gets the next value from the priority list, pending is cleared, and the state returns to PC_RUN.
- Next-PC priority, highest first:
  1. `exc_valid_i`
  2. pending EXC
  3. `br_valid_i`
  4. pending BR
  5. `pc_o`+INST_BYTES
- Merge rule while stalled:
  - A new exception overwrites any pending redirect.
  - A new branch overwrites a pending BR.
  - A new branch is dropped when an EXC is pending, because it is wrong-path.
- `flush_o`=1 for exactly the cycle after `pc_o` is loaded from sources 1–4. Otherwise 0. It is never asserted while the PC is held.
- Arithmetic:
  - The increment wraps modulo 2^ADDR_WIDTH, so all-ones minus (INST_BYTES-1) steps to 0.
  - The low log2(INST_BYTES) bits of every redirect target are forced to 0.
- Async reset assertion mid-operation immediately restores all reset values and discards any pending redirect.

## Timing
- Redirect latency: request in cycle N with `stall_i`=0 gives `pc_o`=target and `flush_o`=1 in cycle N+1.
- Stalled redirect: `pc_o` takes the target on the edge after the first cycle with `stall_i`=0.
- From reset release, the first valid fetch (`pc_valid_o`=1) appears after one edge.
- No combinational path from any input to any output.

## Structure
- The shared package `chinx_pkg` holds:
  - `pc_state_t` enum {PC_BOOT, PC_RUN, PC_HOLD}
  - `redir_kind_t` enum {REDIR_NONE, REDIR_BR, REDIR_EXC}
  - a packed struct `redir_t` {kind, target}
- One sub-module, `chinx_pc_redir_arb`: combinational priority select plus the merge rule. It takes the live requests and the pending entry, and returns the selected next PC, the redirect flag and the next pending entry.
- The top level holds the state register, the PC register, the pending register and the `flush_o` register.

## Test plan
- Reset, then release with no inputs:
  - `pc_o`=BFC0_0000 with `pc_valid_o` 0→1.
  - Then BFC0_0004, BFC0_0008 on successive cycles.
- `br_valid_i`=1 with target 8000_0102 while running: next cycle `pc_o`=8000_0100 and `flush_o`=1. The following cycle `pc_o`=8000_0104 and `flush_o`=0.
- Same cycle `exc_valid_i` (BFC0_0380) and `br_valid_i` (8000_0000): `pc_o`=BFC0_0380.
- Stall for 3 cycles:
  - Branch 8000_0040 in stall cycle 1, exception BFC0_0380 in cycle 2, branch 8000_0080 in cycle 3.
  - `pc_o` holds throughout.
  - After the stall drops, `pc_o`=BFC0_0380 with a single `flush_o` pulse.
- Wrap-around: branch to FFFF_FFFC, then `pc_o`=0000_0000 next cycle with `flush_o`=0.
- Assert `rst` low asynchronously while in PC_HOLD with a pending BR. Outputs return to reset values immediately, and the pending target is never applied after release.
